panel_entry: RTL and testbench
==============================

Name: panel_entry

Overview:
- Front-panel monitor controller between the keyboard scanner (single-cycle key pulses) and the LED display driver.
- Turns hex keys and the LOAD/STORE+/DEC/→PC keys into an address/data entry register pair.
- Runs read/write transactions on the monitor memory port.
- Drives the address/data values and the mode flag to the display, and a PC-load strobe to the CPU control block.

Parameters:
TIMEOUT, 255, cycles mem_req may stay high without mem_ack before abort (≥2)

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  synchronous reset, active-high
key_hex  in  16  one-hot digit pulses, bit n = digit n
key_load  in  1  LOAD key pulse
key_storeinc  in  1  STORE+ key pulse
key_dec  in  1  DEC key pulse
key_topc  in  1  →PC key pulse
mem_req  out  1  transaction request, held until ack or timeout
mem_we  out  1  1 = write, valid while mem_req
mem_addr  out  16  transaction address, stable while mem_req
mem_wdata  out  8  write data, stable while mem_req
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  single-cycle completion
pc_load  out  1  one-cycle strobe, load CPU PC
pc_value  out  16  address sent with pc_load, held afterwards
disp_addr  out  16  entry address register
disp_data  out  8  entry data register
mode_data  out  1  0 = address entry, 1 = data entry
busy  out  1  state != IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; all outputs 0 (mode_data=0, mem_req=0, pc_load=0, err=0, addr=data=pc_value=0).
- Reset takes priority over everything, including mid-transaction.
- A mem_ack arriving after reset is ignored.
- States: IDLE, READ, WRITE. Keys are sampled only in IDLE; pulses while busy are dropped.
- Simultaneous key pulses: exactly one action per cycle, chosen by priority storeinc > dec > load > topc > hex. Among hex bits, the lowest index wins. All others are dropped.
- Any accepted key clears err.
- Hex digit d:
  - mode 0: addr <= {addr[11:0], d}.
  - mode 1: data <= {data[3:0], d}.
  - No memory access; result visible the next cycle.
- load:
  - mode 0: start READ at addr.
  - mode 1: mode_data <= 0, no access.
- storeinc:
  - mode 1: start WRITE of data at addr.
  - mode 0: addr <= addr+1, then READ.
- dec: addr <= addr-1, then READ.
- Address arithmetic: 16-bit modulo (FFFF+1 = 0000, 0000-1 = FFFF).
- topc: pc_value <= addr; pc_load high exactly one cycle, the cycle after acceptance. No access, mode unchanged.
- Key accepted at edge N: mem_req high from cycle N+1 with the final address already applied. mem_addr, mem_we and mem_wdata stay constant while mem_req is high.
- mem_ack is sampled only while mem_req is high and is ignored otherwise.
- mem_ack seen at edge M: mem_req is low in cycle M+1.
- READ ack: data <= mem_rdata, mode_data <= 1, go to IDLE.
- WRITE ack: addr <= addr+1 and enter READ. mem_req drops for exactly one cycle, then re-asserts with the new address.
- Timeout:
  - Cycle counter reset at each mem_req assertion.
  - After TIMEOUT consecutive req-high cycles without ack: err <= 1, mem_req <= 0, go to IDLE.
  - addr, data and mode are unchanged; a timed-out write does no increment and no read.
  - An ack in the same cycle the count expires counts as success.
- busy is high during READ and WRITE, including the one-cycle gap between them.

Test Plan:
- Reset, then key_hex bits 1,2,3,4 on separate cycles → disp_addr = 0x1234, mode_data = 0, mem_req never asserted.
- addr 0x1234, key_load; memory acks 2 cycles after req with rdata 0xA5 → mem_addr = 0x1234, mem_we = 0, disp_data = 0xA5, mode_data = 1, busy low the cycle after ack.
- Mode 1, data 0x3C, addr 0xFFFF, key_storeinc → write of 0x3C at 0xFFFF; then one cycle with req low; then read at 0x0000; disp_addr = 0x0000.
- key_dec at addr 0x0000 → read at 0xFFFF. key_topc at 0x0400 → pc_load high exactly one cycle, pc_value = 0x0400.
- TIMEOUT = 4, mem_ack tied low, key_load → mem_req high 4 cycles then drops, err = 1, disp_data unchanged. Next hex key clears err.
- key_hex[5] together with key_dec, and any key pulse during READ → only dec is executed, busy-time keys are ignored. rst asserted mid-WRITE → all outputs 0 next cycle, a later ack has no effect.

Source files
------------

// File: rtl/panel_entry.sv
// panel_entry: front-panel monitor controller.
//
// Turns single-cycle key pulses from the keyboard scanner into an
// address/data entry register pair, runs read/write transactions on the
// monitor memory port and drives the LED display and a PC-load strobe.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   key_hex[15:0]     one-hot hex digit pulses (bit n = digit n)
//   key_load          LOAD key pulse
//   key_storeinc      STORE+ key pulse
//   key_dec           DEC key pulse
//   key_topc          ->PC key pulse
//   mem_req/we        transaction request / write enable
//   mem_addr/wdata    transaction address / write data (stable while mem_req)
//   mem_rdata/ack     read data / single-cycle completion
//   pc_load/pc_value  one-cycle PC load strobe and the address sent with it
//   disp_addr/data    entry address / data registers
//   mode_data         0 = address entry, 1 = data entry
//   busy              transaction in progress
//   err               sticky timeout flag, cleared by any accepted key
module panel_entry #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_hex,
    input  logic        key_load,
    input  logic        key_storeinc,
    input  logic        key_dec,
    input  logic        key_topc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic [15:0] disp_addr,
    output logic [7:0]  disp_data,
    output logic        mode_data,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            mode_q, mode_d;
    logic [15:0]     pc_q, pc_d;
    logic            pc_load_q, pc_load_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            hex_hit;
    logic [3:0]      hex_digit;

    // Lowest set bit wins when several hex keys pulse together.
    always_comb begin
        hex_digit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (key_hex[i]) begin
                hex_digit = 4'(i);
            end
        end
    end

    assign hex_hit = |key_hex;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mode_d    = mode_q;
        pc_d      = pc_q;
        pc_load_d = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                // Priority: storeinc > dec > load > topc > hex.
                if (key_storeinc) begin
                    err_d = 1'b0;
                    req_d = 1'b1;
                    cnt_d = '0;
                    if (mode_q) begin
                        we_d    = 1'b1;
                        state_d = StWrite;
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        we_d    = 1'b0;
                        state_d = StRead;
                    end
                end else if (key_dec) begin
                    err_d   = 1'b0;
                    addr_d  = addr_q - 16'd1;
                    we_d    = 1'b0;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StRead;
                end else if (key_load) begin
                    err_d = 1'b0;
                    if (mode_q) begin
                        mode_d = 1'b0;
                    end else begin
                        we_d    = 1'b0;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StRead;
                    end
                end else if (key_topc) begin
                    err_d     = 1'b0;
                    pc_d      = addr_q;
                    pc_load_d = 1'b1;
                end else if (hex_hit) begin
                    err_d = 1'b0;
                    if (mode_q) begin
                        data_d = {data_q[3:0], hex_digit};
                    end else begin
                        addr_d = {addr_q[11:0], hex_digit};
                    end
                end
            end
            StRead, StWrite: begin
                if (req_q) begin
                    // An ack on the expiring cycle still counts as success.
                    if (mem_ack) begin
                        req_d = 1'b0;
                        if (state_q == StRead) begin
                            data_d  = mem_rdata;
                            mode_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            addr_d  = addr_q + 16'd1;
                            we_d    = 1'b0;
                            state_d = StRead;
                        end
                    end else if (cnt_q == CntLast) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // One-cycle gap after a write ack: re-issue as a read.
                    req_d = 1'b1;
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            data_q    <= 8'd0;
            mode_q    <= 1'b0;
            pc_q      <= 16'd0;
            pc_load_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            pc_q      <= pc_d;
            pc_load_q <= pc_load_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign pc_load   = pc_load_q;
    assign pc_value  = pc_q;
    assign disp_addr = addr_q;
    assign disp_data = data_q;
    assign mode_data = mode_q;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

endmodule

// File: tb/tb_panel_entry.sv
// Directed bench for panel_entry with a transaction scoreboard.
module tb_panel_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_hex = '0;
    logic        key_load = 1'b0;
    logic        key_storeinc = 1'b0;
    logic        key_dec = 1'b0;
    logic        key_topc = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        pc_load;
    logic [15:0] pc_value;
    logic [15:0] disp_addr;
    logic [7:0]  disp_data;
    logic        mode_data;
    logic        busy;
    logic        err;

    panel_entry #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_hex      (key_hex),
        .key_load     (key_load),
        .key_storeinc (key_storeinc),
        .key_dec      (key_dec),
        .key_topc     (key_topc),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .pc_load      (pc_load),
        .pc_value     (pc_value),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .mode_data    (mode_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   req_rises = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_req && !req_prev) req_rises <= req_rises + 1;
        req_prev <= mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, disp_addr, 0);
        chk({tag, "_data"}, disp_data, 0);
        chk({tag, "_mode"}, mode_data, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_pcld"}, pc_load, 0);
        chk({tag, "_pcval"}, pc_value, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Drive one cycle of key pulses starting at a negedge.
    task automatic press(input logic [15:0] hx, input logic si, input logic dc,
                         input logic ld, input logic tp);
        key_hex = hx; key_storeinc = si; key_dec = dc; key_load = ld; key_topc = tp;
        @(negedge clk);
        key_hex = '0; key_storeinc = 0; key_dec = 0; key_load = 0; key_topc = 0;
    endtask

    task automatic hex(input int d);
        press(16'(1 << d), 0, 0, 0, 0);
    endtask

    // Wait for a request, compare it to the scoreboard head, ack after lat cycles.
    task automatic serve(input int lat, input logic [7:0] rd);
        txn_t e;
        int   waited = 0;
        while (!mem_req && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", mem_req, 1);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (!mem_req || exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int i = 0; i <= lat; i++) begin
            chk("req_hold", mem_req, 1);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", mem_we, e.we);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            if (i == lat) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        chk("req_drop", mem_req, 0);
    endtask

    initial begin
        int base;
        int cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        // Hex address entry, no memory traffic.
        base = req_rises;
        hex(1); hex(2); hex(3); hex(4);
        chk("hex_addr", disp_addr, 16'h1234);
        chk("hex_mode", mode_data, 0);
        chk("hex_noreq", req_rises - base, 0);

        // LOAD read at 0x1234.
        press(0, 0, 0, 1, 0);
        exp_q.push_back('{we: 1'b0, addr: 16'h1234, wdata: 8'h00});
        serve(2, 8'hA5);
        chk("rd_data", disp_data, 8'hA5);
        chk("rd_mode", mode_data, 1);
        chk("rd_busy", busy, 0);

        // Data entry, back to address mode, address 0xFFFF, read 0x3C there.
        hex(3); hex(12);
        chk("data_entry", disp_data, 8'h3C);
        base = req_rises;
        press(0, 0, 0, 1, 0);
        chk("load_mode0", mode_data, 0);
        chk("load_m1_noreq", req_rises - base, 0);
        hex(15); hex(15); hex(15); hex(15);
        chk("addr_ffff", disp_addr, 16'hFFFF);
        press(0, 0, 0, 1, 0);
        exp_q.push_back('{we: 1'b0, addr: 16'hFFFF, wdata: 8'h3C});
        serve(1, 8'h3C);
        chk("mode1_again", mode_data, 1);

        // STORE+ write at 0xFFFF, one-cycle gap, wrap to read at 0x0000.
        press(0, 1, 0, 0, 0);
        exp_q.push_back('{we: 1'b1, addr: 16'hFFFF, wdata: 8'h3C});
        exp_q.push_back('{we: 1'b0, addr: 16'h0000, wdata: 8'h3C});
        serve(1, 8'hEE);
        chk("gap_busy", busy, 1);
        chk("gap_addr", disp_addr, 16'h0000);
        @(negedge clk);
        chk("gap_reassert", mem_req, 1);
        serve(3, 8'h77);    // ack on the expiring cycle counts as success
        chk("wr_rd_data", disp_data, 8'h77);
        chk("wr_rd_err", err, 0);
        chk("wr_rd_busy", busy, 0);

        // DEC at 0x0000 wraps to 0xFFFF.
        press(0, 0, 1, 0, 0);
        exp_q.push_back('{we: 1'b0, addr: 16'hFFFF, wdata: 8'h77});
        serve(0, 8'h11);
        chk("dec_addr", disp_addr, 16'hFFFF);
        chk("dec_data", disp_data, 8'h11);

        // ->PC at 0x0400.
        press(0, 0, 0, 1, 0);
        hex(0); hex(4); hex(0); hex(0);
        chk("addr_0400", disp_addr, 16'h0400);
        base = req_rises;
        press(0, 0, 0, 0, 1);
        chk("pcld_hi", pc_load, 1);
        chk("pcval", pc_value, 16'h0400);
        @(negedge clk);
        chk("pcld_lo", pc_load, 0);
        chk("pcval_held", pc_value, 16'h0400);
        chk("topc_mode", mode_data, 0);
        chk("topc_noreq", req_rises - base, 0);

        // STORE+ in address mode: increment then read.
        press(0, 1, 0, 0, 0);
        exp_q.push_back('{we: 1'b0, addr: 16'h0401, wdata: 8'h11});
        serve(2, 8'h22);
        chk("si_m0_addr", disp_addr, 16'h0401);
        chk("si_m0_data", disp_data, 8'h22);

        // Timeout with ack held low.
        press(0, 0, 0, 1, 0);
        base = req_rises;
        press(0, 0, 0, 1, 0);
        cnt = 0;
        while (mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", cnt, 4);
        chk("to_rises", req_rises - base, 1);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_data", disp_data, 8'h22);
        chk("to_addr", disp_addr, 16'h0401);
        chk("to_mode", mode_data, 0);
        hex(5);
        chk("err_clear", err, 0);
        chk("hex_after_to", disp_addr, 16'h4015);

        // Simultaneous hex[5]+dec, then keys pulsed while busy.
        base = req_rises;
        press(16'h0020, 0, 1, 0, 0);
        exp_q.push_back('{we: 1'b0, addr: 16'h4014, wdata: 8'h22});
        press(16'h0004, 0, 0, 1, 1);
        serve(1, 8'h5A);
        chk("prio_addr", disp_addr, 16'h4014);
        chk("prio_data", disp_data, 8'h5A);
        chk("busy_keys_pc", pc_value, 16'h0400);
        chk("prio_rises", req_rises - base, 1);

        // Reset mid-write; a later ack is ignored.
        press(0, 1, 0, 0, 0);
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'hC3;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk_zero("late_ack");

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
